// File: rtl/dcache_scratchpad_responder_if.sv
// Core-to-dcache request/response bundle. Signal suffixes are written from
// the responder's point of view: _i flows toward the responder, _o away from it.
interface dcache_scratchpad_responder_if #(
    parameter int ADDR_WIDTH = 49,
    parameter int TID_WIDTH  = 7
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [3:0]            req_op_i;
    logic [63:0]           req_wdata_i;
    logic [7:0]            req_be_i;
    logic [2:0]            req_size_i;
    logic [TID_WIDTH-1:0]  req_tid_i;
    logic                  req_need_rsp_i;
    logic                  rsp_valid_o;
    logic [TID_WIDTH-1:0]  rsp_tid_o;
    logic [63:0]           rsp_rdata_o;
    logic                  rsp_error_o;
    logic                  wbuf_empty_o;

    // Core side: issues requests, consumes responses.
    modport master (
        output req_valid_i, req_addr_i, req_op_i, req_wdata_i, req_be_i,
               req_size_i, req_tid_i, req_need_rsp_i,
        input  req_ready_o, rsp_valid_o, rsp_tid_o, rsp_rdata_o, rsp_error_o,
               wbuf_empty_o
    );

    // Responder side: the scratchpad endpoint.
    modport slave (
        input  req_valid_i, req_addr_i, req_op_i, req_wdata_i, req_be_i,
               req_size_i, req_tid_i, req_need_rsp_i,
        output req_ready_o, rsp_valid_o, rsp_tid_o, rsp_rdata_o, rsp_error_o,
               wbuf_empty_o
    );
endinterface

// File: rtl/dcache_scratchpad_responder.sv
// Scratchpad-backed dcache responder: executes load/store/LR/SC in one cycle
// and AMOs as a read-then-write pair, returning tagged one-cycle responses.
module dcache_scratchpad_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 49,
    parameter int TID_WIDTH   = 7
) (
    input logic clk_i,
    input logic rst_i,
    dcache_scratchpad_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // HPDcache request opcode encoding.
    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LR    = 4'd4;
    localparam logic [3:0] OP_SC    = 4'd5;
    localparam logic [3:0] OP_SWAP  = 4'd6;
    localparam logic [3:0] OP_ADD   = 4'd7;
    localparam logic [3:0] OP_AND   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_XOR   = 4'd10;
    localparam logic [3:0] OP_MAX   = 4'd11;
    localparam logic [3:0] OP_MAXU  = 4'd12;
    localparam logic [3:0] OP_MIN   = 4'd13;
    localparam logic [3:0] OP_MINU  = 4'd14;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_AMO_WR = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [63:0]          mem_q [DEPTH_WORDS];
    logic                 resv_valid_q, resv_valid_d;
    logic [IDX_W-1:0]     resv_idx_q, resv_idx_d;
    logic [IDX_W-1:0]     amo_idx_q, amo_idx_d;
    logic [63:0]          amo_old_q, amo_old_d;
    logic [63:0]          amo_opnd_q, amo_opnd_d;
    logic [7:0]           amo_be_q, amo_be_d;
    logic [3:0]           amo_op_q, amo_op_d;
    logic                 amo_dbl_q, amo_dbl_d;
    logic                 amo_lane_q, amo_lane_d;
    logic [TID_WIDTH-1:0] amo_tid_q, amo_tid_d;
    logic                 amo_need_rsp_q, amo_need_rsp_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [TID_WIDTH-1:0] rsp_tid_q, rsp_tid_d;
    logic [63:0]          rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_error_q, rsp_error_d;

    logic [IDX_W-1:0] req_idx;
    logic             in_range;
    logic             accept;
    logic             is_amo;
    logic             sc_ok;
    logic [63:0]      rd_word;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [63:0]      wr_data;
    logic [31:0]      a32, b32, r32;
    logic [63:0]      r64, amo_wdata;
    logic [1:0]       unused_addr_bits;

    function automatic logic [63:0] byte_merge(input logic [63:0] old_w,
                                               input logic [63:0] new_w,
                                               input logic [7:0]  be);
        logic [63:0] res;
        for (int b = 0; b < 8; b++) begin
            res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    assign unused_addr_bits = bus.req_addr_i[1:0];

    assign req_idx  = bus.req_addr_i[3 +: IDX_W];
    assign in_range = (bus.req_addr_i[ADDR_WIDTH-1:3+IDX_W] == '0);
    assign rd_word  = mem_q[req_idx];
    assign is_amo   = (bus.req_op_i >= OP_SWAP) && (bus.req_op_i <= OP_MINU);
    assign sc_ok    = resv_valid_q && (resv_idx_q == req_idx);
    assign accept   = bus.req_valid_i && bus.req_ready_o;

    assign bus.req_ready_o  = !rst_i && (state_q == ST_IDLE);
    assign bus.wbuf_empty_o = (state_q != ST_AMO_WR);
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_tid_o    = rsp_tid_q;
    assign bus.rsp_rdata_o  = rsp_rdata_q;
    assign bus.rsp_error_o  = rsp_error_q;

    // AMO datapath: combine the latched old word and operand (64-bit or one 32-bit lane).
    always_comb begin
        a32 = amo_lane_q ? amo_old_q[63:32]  : amo_old_q[31:0];
        b32 = amo_lane_q ? amo_opnd_q[63:32] : amo_opnd_q[31:0];
        r64 = amo_opnd_q;
        r32 = b32;
        case (amo_op_q)
            OP_ADD:  begin r64 = amo_old_q + amo_opnd_q; r32 = a32 + b32; end
            OP_AND:  begin r64 = amo_old_q & amo_opnd_q; r32 = a32 & b32; end
            OP_OR:   begin r64 = amo_old_q | amo_opnd_q; r32 = a32 | b32; end
            OP_XOR:  begin r64 = amo_old_q ^ amo_opnd_q; r32 = a32 ^ b32; end
            OP_MAX:  begin
                r64 = ($signed(amo_old_q) > $signed(amo_opnd_q)) ? amo_old_q : amo_opnd_q;
                r32 = ($signed(a32) > $signed(b32)) ? a32 : b32;
            end
            OP_MAXU: begin
                r64 = (amo_old_q > amo_opnd_q) ? amo_old_q : amo_opnd_q;
                r32 = (a32 > b32) ? a32 : b32;
            end
            OP_MIN:  begin
                r64 = ($signed(amo_old_q) < $signed(amo_opnd_q)) ? amo_old_q : amo_opnd_q;
                r32 = ($signed(a32) < $signed(b32)) ? a32 : b32;
            end
            OP_MINU: begin
                r64 = (amo_old_q < amo_opnd_q) ? amo_old_q : amo_opnd_q;
                r32 = (a32 < b32) ? a32 : b32;
            end
            default: ; // SWAP: operand passes through
        endcase
        // Both halves carry the 32-bit result; the latched byte enables pick the lane.
        amo_wdata = amo_dbl_q ? r64 : {r32, r32};
    end

    // Request execution, reservation tracking and response formation.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d        = state_q;
        resv_valid_d   = resv_valid_q;
        resv_idx_d     = resv_idx_q;
        amo_idx_d      = amo_idx_q;
        amo_old_d      = amo_old_q;
        amo_opnd_d     = amo_opnd_q;
        amo_be_d       = amo_be_q;
        amo_op_d       = amo_op_q;
        amo_dbl_d      = amo_dbl_q;
        amo_lane_d     = amo_lane_q;
        amo_tid_d      = amo_tid_q;
        amo_need_rsp_d = amo_need_rsp_q;
        rsp_valid_d    = 1'b0;
        rsp_tid_d      = rsp_tid_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_error_d    = rsp_error_q;
        wr_en          = 1'b0;
        wr_idx         = req_idx;
        wr_data        = byte_merge(rd_word, bus.req_wdata_i, bus.req_be_i);

        case (state_q)
            ST_IDLE: begin
                if (accept && in_range && is_amo) begin
                    state_d        = ST_AMO_WR;
                    amo_idx_d      = req_idx;
                    amo_old_d      = rd_word;
                    amo_opnd_d     = bus.req_wdata_i;
                    amo_be_d       = bus.req_be_i;
                    amo_op_d       = bus.req_op_i;
                    amo_dbl_d      = (bus.req_size_i == 3'd3);
                    amo_lane_d     = bus.req_addr_i[2];
                    amo_tid_d      = bus.req_tid_i;
                    amo_need_rsp_d = bus.req_need_rsp_i;
                end else if (accept) begin
                    rsp_valid_d = bus.req_need_rsp_i;
                    rsp_tid_d   = bus.req_tid_i;
                    rsp_error_d = !in_range;
                    rsp_rdata_d = '0;
                    if (in_range) begin
                        case (bus.req_op_i)
                            OP_STORE: begin
                                wr_en = 1'b1;
                                if (resv_idx_q == req_idx) resv_valid_d = 1'b0;
                            end
                            OP_LR: begin
                                rsp_rdata_d  = rd_word;
                                resv_valid_d = 1'b1;
                                resv_idx_d   = req_idx;
                            end
                            OP_SC: begin
                                wr_en        = sc_ok;
                                rsp_rdata_d  = sc_ok ? 64'd0 : 64'd1;
                                resv_valid_d = 1'b0;
                            end
                            default: rsp_rdata_d = rd_word; // LOAD
                        endcase
                    end
                end
            end
            default: begin // ST_AMO_WR
                wr_en       = 1'b1;
                wr_idx      = amo_idx_q;
                wr_data     = byte_merge(amo_old_q, amo_wdata, amo_be_q);
                if (resv_idx_q == amo_idx_q) resv_valid_d = 1'b0;
                rsp_valid_d = amo_need_rsp_q;
                rsp_tid_d   = amo_tid_q;
                rsp_rdata_d = amo_old_q;
                rsp_error_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Scratchpad write port; a new request sees this write through the read path.
    // NOTE: the array has no reset, so it maps onto plain RAM; contents are undefined until written.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_idx] <= wr_data;
    end

    // Control, AMO context and response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst_i) begin
            state_q        <= ST_IDLE;
            resv_valid_q   <= 1'b0;
            resv_idx_q     <= '0;
            amo_idx_q      <= '0;
            amo_old_q      <= '0;
            amo_opnd_q     <= '0;
            amo_be_q       <= '0;
            amo_op_q       <= OP_LOAD;
            amo_dbl_q      <= 1'b0;
            amo_lane_q     <= 1'b0;
            amo_tid_q      <= '0;
            amo_need_rsp_q <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_tid_q      <= '0;
            rsp_rdata_q    <= '0;
            rsp_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            resv_valid_q   <= resv_valid_d;
            resv_idx_q     <= resv_idx_d;
            amo_idx_q      <= amo_idx_d;
            amo_old_q      <= amo_old_d;
            amo_opnd_q     <= amo_opnd_d;
            amo_be_q       <= amo_be_d;
            amo_op_q       <= amo_op_d;
            amo_dbl_q      <= amo_dbl_d;
            amo_lane_q     <= amo_lane_d;
            amo_tid_q      <= amo_tid_d;
            amo_need_rsp_q <= amo_need_rsp_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_tid_q      <= rsp_tid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_error_q    <= rsp_error_d;
        end
    end
endmodule

// File: tb/tb_dcache_scratchpad_responder.sv
// Scoreboard bench for dcache_scratchpad_responder: a driver feeds directed and
// random requests through a behavioural memory model; a monitor checks responses.
module tb_dcache_scratchpad_responder;
    localparam int DEPTH = 1024;
    localparam int AW    = 49;
    localparam int TW    = 7;
    localparam int IW    = $clog2(DEPTH);
    localparam int POOL  = 16;

    localparam logic [3:0] LOAD = 4'd0,  STORE = 4'd1,  LR = 4'd4,  SC = 4'd5;
    localparam logic [3:0] SWAP = 4'd6,  ADD = 4'd7,    AND_ = 4'd8, OR_ = 4'd9;
    localparam logic [3:0] XOR_ = 4'd10, MAX = 4'd11,   MAXU = 4'd12, MIN = 4'd13;
    localparam logic [3:0] MINU = 4'd14;

    typedef struct {
        logic [TW-1:0] tid;
        logic [63:0]   rdata;
        logic          err;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_scratchpad_responder_if #(.ADDR_WIDTH(AW), .TID_WIDTH(TW)) bus_if ();

    dcache_scratchpad_responder #(
        .DEPTH_WORDS(DEPTH), .ADDR_WIDTH(AW), .TID_WIDTH(TW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus_if)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];

    // Reference model state: memory contents and the LR reservation.
    logic [63:0] mdl [DEPTH];
    bit          rv;
    int          ridx;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                          input logic [7:0] be);
        logic [63:0] r = o;
        for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // New word value for an AMO, computed on the lane as integers.
    function automatic logic [63:0] amo_calc(input logic [3:0] op, input logic [2:0] size,
                                             input logic lane, input logic [63:0] o,
                                             input logic [63:0] n);
        logic [63:0] mask, a, b, r;
        longint      sa, sb_;
        int          sh;
        sh   = (size == 3'd3) ? 0 : (lane ? 32 : 0);
        mask = (size == 3'd3) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a = (o >> sh) & mask;
        b = (n >> sh) & mask;
        if (size == 3'd3) begin
            sa = longint'(a); sb_ = longint'(b);
        end else begin
            sa = longint'($signed(a[31:0])); sb_ = longint'($signed(b[31:0]));
        end
        case (op)
            SWAP:    r = b;
            ADD:     r = a + b;
            AND_:    r = a & b;
            OR_:     r = a | b;
            XOR_:    r = a ^ b;
            MAX:     r = (sa > sb_) ? a : b;
            MAXU:    r = (a > b) ? a : b;
            MIN:     r = (sa < sb_) ? a : b;
            default: r = (a < b) ? a : b; // MINU
        endcase
        return (r & mask) << sh;
    endfunction

    task automatic model(input logic [3:0] op, input logic [AW-1:0] addr,
                         input logic [63:0] wdata, input logic [7:0] be, input logic [2:0] size,
                         output logic [63:0] rdata, output logic err);
        int          idx;
        logic [63:0] old;
        idx = int'(addr[3 +: IW]);
        err = ((64'(addr) >> 3) >= 64'(DEPTH));
        rdata = '0;
        if (err) return;
        old = mdl[idx];
        case (op)
            LOAD:  rdata = old;
            STORE: begin
                mdl[idx] = merge(old, wdata, be);
                if (rv && ridx == idx) rv = 0;
            end
            LR: begin
                rdata = old; rv = 1; ridx = idx;
            end
            SC: begin
                if (rv && ridx == idx) mdl[idx] = merge(old, wdata, be);
                else rdata = 64'd1;
                rv = 0;
            end
            default: begin
                mdl[idx] = merge(old, amo_calc(op, size, addr[2], old, wdata), be);
                if (rv && ridx == idx) rv = 0;
                rdata = old;
            end
        endcase
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus_if.rsp_valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual tid=0x%h expected no response", bus_if.rsp_tid_o);
            end else begin
                e = sb.pop_front();
                check("rsp_tid",   64'(bus_if.rsp_tid_o),   64'(e.tid));
                check("rsp_rdata", bus_if.rsp_rdata_o,      e.rdata);
                check("rsp_error", 64'(bus_if.rsp_error_o), 64'(e.err));
                check("rsp_cycle", 64'(cyc),                64'(e.due));
            end
        end
    end

    // Drive one request for one cycle, updating the model at acceptance.
    task automatic issue(input logic [3:0] op, input logic [AW-1:0] addr,
                         input logic [63:0] wdata, input logic [7:0] be, input logic [2:0] size,
                         input logic [TW-1:0] tid, input bit need);
        logic [63:0] rd;
        logic        err;
        bit          amo;
        @(negedge clk);
        bus_if.req_valid_i    = 1'b1;
        bus_if.req_op_i       = op;
        bus_if.req_addr_i     = addr;
        bus_if.req_wdata_i    = wdata;
        bus_if.req_be_i       = be;
        bus_if.req_size_i     = size;
        bus_if.req_tid_i      = tid;
        bus_if.req_need_rsp_i = need;
        check("req_ready_idle", 64'(bus_if.req_ready_o), 64'd1);
        check("wbuf_empty_idle", 64'(bus_if.wbuf_empty_o), 64'd1);
        model(op, addr, wdata, be, size, rd, err);
        amo = (op >= SWAP) && !err;
        if (need) sb.push_back('{tid: tid, rdata: rd, err: err, due: cyc + (amo ? 2 : 1)});
        @(posedge clk);
        if (amo) begin
            @(negedge clk);
            bus_if.req_valid_i = 1'b0;
            check("req_ready_amo_wr", 64'(bus_if.req_ready_o), 64'd0);
            check("wbuf_empty_amo_wr", 64'(bus_if.wbuf_empty_o), 64'd0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus_if.req_valid_i = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"},  64'(bus_if.rsp_valid_o),  64'd0);
        check({tag, "_rsp_tid"},    64'(bus_if.rsp_tid_o),    64'd0);
        check({tag, "_rsp_rdata"},  bus_if.rsp_rdata_o,       64'd0);
        check({tag, "_rsp_error"},  64'(bus_if.rsp_error_o),  64'd0);
        check({tag, "_req_ready"},  64'(bus_if.req_ready_o),  64'd0);
        check({tag, "_wbuf_empty"}, 64'(bus_if.wbuf_empty_o), 64'd1);
    endtask

    initial begin
        logic [3:0]    ops [13];
        logic [3:0]    op;
        logic [AW-1:0] addr;
        logic [7:0]    be;
        logic [2:0]    size;
        logic          lane;
        int            w;

        ops = '{LOAD, STORE, LR, SC, SWAP, ADD, AND_, OR_, XOR_, MAX, MAXU, MIN, MINU};
        rv = 0;
        ridx = 0;
        bus_if.req_valid_i    = 1'b0;
        bus_if.req_op_i       = LOAD;
        bus_if.req_addr_i     = '0;
        bus_if.req_wdata_i    = '0;
        bus_if.req_be_i       = '0;
        bus_if.req_size_i     = 3'd3;
        bus_if.req_tid_i      = '0;
        bus_if.req_need_rsp_i = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(bus_if.req_ready_o), 64'd1);

        // Back-to-back store then load, then a byte store.
        issue(STORE, 49'h100, 64'h1122334455667788, 8'hFF, 3'd3, 7'd5, 1);
        issue(LOAD,  49'h100, 64'h0, 8'h00, 3'd3, 7'd6, 1);
        issue(STORE, 49'h100, 64'h0000000000AB0000, 8'h04, 3'd3, 7'd7, 1);
        issue(LOAD,  49'h100, 64'h0, 8'h00, 3'd3, 7'd8, 1);

        // LR/SC pair, then a failing second SC.
        issue(LR,   49'h200, 64'h0, 8'h00, 3'd3, 7'd1, 1);
        issue(SC,   49'h200, 64'h7, 8'hFF, 3'd3, 7'd2, 1);
        issue(LOAD, 49'h200, 64'h0, 8'h00, 3'd3, 7'd3, 1);
        issue(SC,   49'h200, 64'h9, 8'hFF, 3'd3, 7'd4, 1);
        issue(LOAD, 49'h200, 64'h0, 8'h00, 3'd3, 7'd10, 1);

        // Signed 32-bit MIN on the low lane.
        issue(STORE, 49'h300, 64'h5, 8'hFF, 3'd3, 7'd11, 1);
        issue(MIN,   49'h300, 64'hFFFFFFFF, 8'h0F, 3'd2, 7'd12, 1);
        issue(LOAD,  49'h300, 64'h0, 8'h00, 3'd3, 7'd13, 1);

        // Out-of-range load and store.
        issue(LOAD,  49'(DEPTH * 8), 64'h0, 8'h00, 3'd3, 7'd9, 1);
        issue(STORE, 49'(DEPTH * 8 + 8), 64'hDEAD, 8'hFF, 3'd3, 7'd14, 1);
        idle(3);

        // Initialise the random pool, then random traffic over it.
        for (int i = 0; i < POOL; i++)
            issue(STORE, 49'(i * 8), {$urandom, $urandom}, 8'hFF, 3'd3, 7'd0, 0);
        for (int n = 0; n < 400; n++) begin
            op   = ops[$urandom_range(0, 12)];
            w    = int'($urandom_range(0, POOL - 1));
            lane = 1'($urandom_range(0, 1));
            size = 3'd3;
            be   = 8'($urandom);
            if (op >= SWAP) begin
                size = $urandom_range(0, 1) ? 3'd3 : 3'd2;
                be   = (size == 3'd3) ? 8'hFF : (lane ? 8'hF0 : 8'h0F);
            end
            addr = 49'(w * 8) | (49'(lane) << 2);
            if ($urandom_range(0, 15) == 0) addr = addr + 49'(DEPTH * 8 * $urandom_range(1, 4));
            issue(op, addr, {$urandom, $urandom}, be, size, 7'($urandom),
                  $urandom_range(0, 7) != 0);
            if ($urandom_range(0, 7) == 0) idle(1);
        end

        // Reset during AMO_WR: no write, no response, reservation dropped.
        issue(STORE, 49'h400, 64'hCAFEF00D12345678, 8'hFF, 3'd3, 7'd0, 0);
        issue(LR,    49'h480, 64'h0, 8'h00, 3'd3, 7'd0, 0);
        idle(2);
        @(negedge clk);
        bus_if.req_valid_i    = 1'b1;
        bus_if.req_op_i       = ADD;
        bus_if.req_addr_i     = 49'h400;
        bus_if.req_wdata_i    = 64'h1;
        bus_if.req_be_i       = 8'hFF;
        bus_if.req_size_i     = 3'd3;
        bus_if.req_tid_i      = 7'd33;
        bus_if.req_need_rsp_i = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_outputs("mid_amo_reset");
        @(negedge clk);
        bus_if.req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rv  = 0;
        issue(LOAD, 49'h400, 64'h0, 8'h00, 3'd3, 7'd34, 1);
        issue(SC,   49'h480, 64'h5, 8'hFF, 3'd3, 7'd35, 1);

        // Drain outstanding expectations.
        idle(6);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcache_scratchpad_responder.md
# dcache_scratchpad_responder

Responder-side model of the core-to-HPDcache request/response interface. It accepts load, store, LR/SC and AMO requests from the core-side dcache interface, executes them against a local 64-bit-wide scratchpad, and returns tagged responses. It serves as a synthesizable memory endpoint for core-tile bring-up and for verifying the core's tag-tracking and back-pressure logic without a full HPDcache.

## Interface
- DEPTH_WORDS, 1024: number of 64-bit scratchpad words; power of two.
- ADDR_WIDTH, 49: request address width.
- TID_WIDTH, 7: transaction tag width.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous and active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  responder can accept a request this cycle.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_op_i  in  hpdcache_req_op_t  operation (HPDCACHE_REQ_LOAD/STORE/AMO_*).
- req_wdata_i  in  64  store/AMO operand, lane-aligned.
- req_be_i  in  8  byte enables for stores/SC/AMO.
- req_size_i  in  3  log2 access bytes (2 = word, 3 = double).
- req_tid_i  in  TID_WIDTH  transaction tag.
- req_need_rsp_i  in  1  a response is produced only when set.
- rsp_valid_o  out  1  one-cycle response pulse; no back-pressure.
- rsp_tid_o  out  TID_WIDTH  tag of the responded request.
- rsp_rdata_o  out  64  full aligned 64-bit word (old value for AMO; SC status).
- rsp_error_o  out  1  address out of range.
- wbuf_empty_o  out  1  no write outstanding.

## Operation
- Handshake: request accepted when req_valid_i && req_ready_o at a rising edge.
- Word index = req_addr_i[3 +: log2(DEPTH_WORDS)]. Out of range if req_addr_i[ADDR_WIDTH-1:3] >= DEPTH_WORDS: no write, no reservation change, rdata 0, error 1.
- FSM states: IDLE, AMO_WR.
  - IDLE: req_ready_o = 1. LOAD/STORE/LR/SC complete in the acceptance cycle. AMO: latch index, old word, operand and tag, then go to AMO_WR.
  - AMO_WR: req_ready_o = 0. Write the computed value with req_be_i as latched, then return to IDLE.
- STORE: byte-masked write at the acceptance edge. rdata 0.
- LOAD: rdata = word before any same-cycle write.
- LR: behaves as LOAD and sets the reservation {valid = 1, index}.
- SC:
  - Reservation valid and index matches: perform the masked write, rdata = 0.
  - Otherwise: no write, rdata = 1.
  - The reservation is cleared in both cases.
- Any STORE or AMO write to the reserved index clears the reservation.
- AMO arithmetic:
  - size 3: 64-bit.
  - size 2: 32-bit on the lane selected by addr[2]; MIN/MAX compare signed, MINU/MAXU unsigned.
  - SWAP writes the operand.
  - ADD wraps modulo 2^width.
- The tag is echoed unchanged. The responder never checks tag reuse.

## Timing
- Reset values: rsp_valid_o 0, rsp_tid_o 0, rsp_rdata_o 0, rsp_error_o 0, req_ready_o 0 while rst_i is high and 1 afterwards, wbuf_empty_o 1, state IDLE, reservation invalid. Scratchpad contents are not reset.
- Load, store, LR, SC and errors: accepted at edge N; rsp_valid_o is high for exactly cycle N+1.
- AMO: accepted at edge N; AMO_WR during cycle N+1, with the write at edge N+1. rsp_valid_o is high in cycle N+2. req_ready_o is low in cycle N+1 only, so the throughput is one AMO every 2 cycles.
- wbuf_empty_o = 0 exactly while in AMO_WR.
- A request accepted at N+1 observes the write from edge N (store-to-load forwarding through the array).
- need_rsp = 0: the operation executes and rsp_valid_o stays low for that transaction.
- Reset asserted mid-AMO: the AMO write and response are abandoned, and all outputs go to their reset values immediately.

## Test plan
- Reset then back-to-back requests:
  - Store 0x1122334455667788 to addr 0x100 (be 0xFF, tid 5).
  - Next cycle, load 0x100 (tid 6).
  - Expected: response tid 5 with rdata 0 at N+1; tid 6 with rdata 0x1122334455667788 at N+2.
- Byte store: be 0x04, wdata 0x0000000000AB0000 to 0x100; a following load returns 0x1122334455AB7788.
- LR/SC:
  - LR 0x200 (tid 1), then SC 0x200 with data 0x7, be 0xFF: rdata 0 and the memory holds 7.
  - A second SC to 0x200: rdata 1, and the memory is unchanged.
- Signed 32-bit MIN:
  - Word at 0x300 = 0x00000000_00000005; AMO_MIN, size 2, addr 0x300, operand 0xFFFFFFFF (-1), be 0x0F.
  - req_ready_o is low one cycle; response at N+2 with rdata 0x5.
  - A following load returns 0x00000000_FFFFFFFF.
- Out-of-range address: load at address DEPTH_WORDS*8, tid 9 -> rsp_valid_o at N+1 with tid 9, error 1, rdata 0.
- Reset mid-AMO: assert rst_i during AMO_WR -> no response and no write; the memory word retains its old value.
